if_fetch: RTL and testbench



---
 rtl/if_fetch.sv | 91 +++++++++
 tb/tb_if_fetch.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles 32-bit little-endian instructions from
// four byte reads and holds each one in a one-deep valid/stall output slot.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  input  logic        stall,
  input  logic        br,
  input  logic [31:0] br_addr,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  typedef enum logic [1:0] {B0 = 2'd0, B1 = 2'd1, B2 = 2'd2, B3 = 2'd3} cnt_e;

  cnt_e        cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [23:0] bytes_q, bytes_d;
  logic        valid_q, valid_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] inst_q, inst_d;

  logic consume, slot_free, accept;

  assign consume   = valid_q & ~stall;
  assign slot_free = ~valid_q | consume;
  // Only the last byte waits for the slot, so bytes 0..2 overlap the held output.
  assign mem_req   = ~rst & ~br & ~((cnt_q == B3) & ~slot_free);
  assign mem_addr  = rst ? '0 : pc_q + {30'b0, cnt_q};
  assign accept    = mem_req & mem_ack;

  assign if_valid = valid_q;
  assign if_pc    = ifpc_q;
  assign if_inst  = inst_q;

  always_comb begin
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    bytes_d = bytes_q;
    valid_d = valid_q;
    ifpc_d  = ifpc_q;
    inst_d  = inst_q;
    if (br) begin
      pc_d    = br_addr;
      cnt_d   = B0;
      valid_d = 1'b0;
    end else begin
      if (consume)
        valid_d = 1'b0;
      if (accept) begin
        unique case (cnt_q)
          B0: begin bytes_d[7:0]   = mem_rdata; cnt_d = B1; end
          B1: begin bytes_d[15:8]  = mem_rdata; cnt_d = B2; end
          B2: begin bytes_d[23:16] = mem_rdata; cnt_d = B3; end
          B3: begin
            inst_d  = {mem_rdata, bytes_q};
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            cnt_d   = B0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      cnt_q   <= B0;
      bytes_q <= '0;
      valid_q <= 1'b0;
      ifpc_q  <= '0;
      inst_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      bytes_q <= bytes_d;
      valid_q <= valid_d;
      ifpc_q  <= ifpc_d;
      inst_q  <= inst_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: per-cycle vector table plus a wait-state sequence.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst, mem_req, mem_ack, stall, br, if_valid;
  logic [31:0] mem_addr, br_addr, if_pc, if_inst;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .br(br),
    .br_addr(br_addr), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
  );

  // Byte memory: addresses 0..3 hold 0x00500513, elsewhere byte = low address byte.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h50;
      32'd3:   return 8'h00;
      default: return a[7:0];
    endcase
  endfunction

  always_comb mem_rdata = mem_byte(mem_addr);

  typedef struct {
    logic        rst, stall, br, ack;
    logic [31:0] br_addr;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc, inst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic b,
                              input logic [31:0] ba, input logic q,
                              input logic [31:0] a, input logic v,
                              input logic [31:0] p, input logic [31:0] i);
    vec_t t;
    t.rst = r; t.stall = s; t.br = b; t.ack = 1'b1; t.br_addr = ba;
    t.req = q; t.addr = a; t.valid = v; t.pc = p; t.inst = i;
    return t;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step%0d got=%h exp=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b,
                       input logic [31:0] ba, input logic ack);
    @(negedge clk);
    rst = r; stall = s; br = b; br_addr = ba; mem_ack = ack;
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br = 1'b0; br_addr = '0; mem_ack = 1'b1;
    @(posedge clk);

    //                rst stall br  br_addr       req addr          vld if_pc         if_inst
    vecs.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
    // 1: zero-wait fetch of the first instruction
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h1,         0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h2,         0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h3,         0, 32'h0,         32'h0));
    // 2: stall holds output, fetch proceeds up to the final byte
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h4,         1, 32'h0,         32'h00500513));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h5,         1, 32'h0,         32'h00500513));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h6,         1, 32'h0,         32'h00500513));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h7,         1, 32'h0,         32'h00500513));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h7,         1, 32'h0,         32'h00500513));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h7,         1, 32'h0,         32'h00500513));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h8,         1, 32'h4,         32'h07060504));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h9,         0, 32'h4,         32'h07060504));
    // 3: redirect during B2 with ack asserted
    vecs.push_back(mk(0, 0, 1, 32'h100,       0, 32'hA,         0, 32'h4,         32'h07060504));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h100,       0, 32'h4,         32'h07060504));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h101,       0, 32'h4,         32'h07060504));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h102,       0, 32'h4,         32'h07060504));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h103,       0, 32'h4,         32'h07060504));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h104,       1, 32'h100,       32'h03020100));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h105,       0, 32'h100,       32'h03020100));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h106,       0, 32'h100,       32'h03020100));
    // 4+5: redirect on the B3 cycle drops it; unaligned target wraps past 2^32
    vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFE,  0, 32'h107,       0, 32'h100,       32'h03020100));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'hFFFFFFFE,  0, 32'h100,       32'h03020100));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'hFFFFFFFF,  0, 32'h100,       32'h03020100));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h0,         0, 32'h100,       32'h03020100));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h1,         0, 32'h100,       32'h03020100));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h2,         1, 32'hFFFFFFFE,  32'h0513FFFE));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h3,         1, 32'hFFFFFFFE,  32'h0513FFFE));
    // 6: reset mid-fetch with a held instruction
    vecs.push_back(mk(1, 1, 0, 32'h0,         0, 32'h0,         1, 32'hFFFFFFFE,  32'h0513FFFE));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h1,         0, 32'h0,         32'h0));

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].stall, vecs[k].br, vecs[k].br_addr, vecs[k].ack);
      chk("mem_req",  k, {31'b0, mem_req},  {31'b0, vecs[k].req});
      chk("mem_addr", k, mem_addr,          vecs[k].addr);
      chk("if_valid", k, {31'b0, if_valid}, {31'b0, vecs[k].valid});
      chk("if_pc",    k, if_pc,             vecs[k].pc);
      chk("if_inst",  k, if_inst,           vecs[k].inst);
    end

    // Wait-state memory: each byte acked one cycle late; address must hold.
    drive(1, 0, 0, 32'h0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      drive(0, 0, 0, 32'h0, 1'b0);
      chk("ws_req",       100 + b, {31'b0, mem_req}, 32'h1);
      chk("ws_addr_wait", 100 + b, mem_addr, b);
      drive(0, 0, 0, 32'h0, 1'b1);
      chk("ws_addr_ack",  100 + b, mem_addr, b);
      chk("ws_valid",     100 + b, {31'b0, if_valid}, 32'h0);
    end
    drive(0, 1, 0, 32'h0, 1'b0);
    chk("ws_valid_out", 200, {31'b0, if_valid}, 32'h1);
    chk("ws_inst",      200, if_inst, 32'h00500513);
    chk("ws_pc",        200, if_pc, 32'h0);
    chk("ws_next_addr", 200, mem_addr, 32'h4);

    // br while stalled with a valid instruction clears the slot.
    drive(0, 1, 1, 32'h40, 1'b1);
    chk("brst_req", 300, {31'b0, mem_req}, 32'h0);
    drive(0, 1, 0, 32'h0, 1'b1);
    chk("brst_valid", 301, {31'b0, if_valid}, 32'h0);
    chk("brst_addr",  301, mem_addr, 32'h40);
    chk("brst_inst",  301, if_inst, 32'h00500513);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
